// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_pkg
//  Purpose  : Shared AES field definitions: byte type, reduction polynomial,
//             S-box affine constant, the affine transform, GF(2^4) and
//             GF((2^4)^2) arithmetic, and the isomorphic mapping matrices
//             between the AES polynomial basis and the composite field.
//  Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

   typedef logic [7:0]      byte_t;
   typedef logic [3:0]      nib_t;
   // Packed 8x8 bit matrix; element [i] is the image of input bit i.
   typedef logic [7:0][7:0] mat8_t;

   // x^8 = x^4 + x^3 + x + 1 in the AES field.
   localparam byte_t AES_POLY      = 8'h1B;
   localparam byte_t SBOX_AFFINE_C = 8'h63;
   // Ground field GF(2^4) modulo z^4 + z + 1, so z^4 = z + 1.
   localparam nib_t  GF16_POLY     = 4'h3;
   // Extension w^2 + w + lambda with lambda = z^3; Tr(z^3) = 1 so the
   // quadratic has no root in GF(2^4) and the extension is a field.
   localparam nib_t  GF16_LAMBDA   = 4'h8;

   // FIPS-197 affine transform: bit i = b[i]^b[i+4]^b[i+5]^b[i+6]^b[i+7]
   // (indices mod 8), i.e. b xored with its left rotations by 1..4.
   function automatic byte_t affine(input byte_t b);
      byte_t r;
      r = b
        ^ {b[6:0], b[7]}
        ^ {b[5:0], b[7:6]}
        ^ {b[4:0], b[7:5]}
        ^ {b[3:0], b[7:4]};
      return r ^ SBOX_AFFINE_C;
   endfunction

   // GF(2^4) multiply, shift-and-add with reduction by z^4 + z + 1.
   function automatic nib_t gf16_mul(input nib_t a, input nib_t b);
      nib_t r;
      nib_t t;
      nib_t s;
      r = '0;
      t = a;
      s = b;
      for (int i = 0; i < 4; i++) begin
         if (s[0]) r = r ^ t;
         s = s >> 1;
         t = t[3] ? ((t << 1) ^ GF16_POLY) : (t << 1);
      end
      return r;
   endfunction

   // GF(2^4) inverse as a^14 (a^15 = 1); zero maps to zero naturally.
   function automatic nib_t gf16_inv(input nib_t a);
      nib_t a2;
      nib_t a4;
      nib_t a8;
      a2 = gf16_mul(a, a);
      a4 = gf16_mul(a2, a2);
      a8 = gf16_mul(a4, a4);
      return gf16_mul(gf16_mul(a8, a4), a2);
   endfunction

   // Composite-field multiply, element {h,l} = h*w + l, w^2 = w + lambda.
   function automatic byte_t gf16sq_mul(input byte_t a, input byte_t b);
      nib_t hh;
      nib_t hl;
      nib_t ll;
      hh = gf16_mul(a[7:4], b[7:4]);
      hl = gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]);
      ll = gf16_mul(a[3:0], b[3:0]);
      return {hh ^ hl, gf16_mul(hh, GF16_LAMBDA) ^ ll};
   endfunction

   // Composite-field inverse: (h*w + l)^-1 = (h*w + (h^l)) / D with
   // D = h^2*lambda + h*l + l^2. D = 0 only for zero, which yields zero.
   function automatic byte_t gf16sq_inv(input byte_t a);
      nib_t h;
      nib_t l;
      nib_t d;
      nib_t di;
      h  = a[7:4];
      l  = a[3:0];
      d  = gf16_mul(gf16_mul(h, h), GF16_LAMBDA) ^ gf16_mul(h, l) ^ gf16_mul(l, l);
      di = gf16_inv(d);
      return {gf16_mul(h, di), gf16_mul(h ^ l, di)};
   endfunction

   // Linear map over GF(2): XOR of the columns selected by the set bits.
   function automatic byte_t mat_apply(input mat8_t m, input byte_t a);
      logic [63:0] mm;
      byte_t       r;
      byte_t       t;
      mm = m;
      r  = '0;
      t  = a;
      for (int i = 0; i < 8; i++) begin
         if (t[0]) r = r ^ mm[7:0];
         t  = t >> 1;
         mm = mm >> 8;
      end
      return r;
   endfunction

   // Find a root beta of the AES polynomial inside the composite field and
   // send x^i to beta^i; that linear map is a field isomorphism.
   function automatic mat8_t build_iso_map();
      mat8_t m;
      mat8_t cols;
      byte_t b;
      byte_t p2;
      byte_t p3;
      byte_t p4;
      byte_t p5;
      byte_t p6;
      byte_t p7;
      byte_t p8;
      logic  found;
      m     = '0;
      found = 1'b0;
      for (int ci = 2; ci < 256; ci++) begin
         b    = byte_t'(ci);
         p2   = gf16sq_mul(b, b);
         p3   = gf16sq_mul(p2, b);
         p4   = gf16sq_mul(p2, p2);
         p5   = gf16sq_mul(p4, b);
         p6   = gf16sq_mul(p3, p3);
         p7   = gf16sq_mul(p6, b);
         p8   = gf16sq_mul(p4, p4);
         cols = {p7, p6, p5, p4, p3, p2, b, 8'h01};
         // beta^8 must equal the reduction pattern evaluated at beta
         if (!found && (mat_apply(cols, AES_POLY) == p8)) begin
            m     = cols;
            found = 1'b1;
         end
      end
      return m;
   endfunction

   // Inverse matrix: column j is the preimage of the unit vector e_j.
   function automatic mat8_t build_iso_unmap(input mat8_t m);
      logic [63:0] acc;
      byte_t       s;
      byte_t       v;
      acc = '0;
      for (int si = 0; si < 256; si++) begin
         s = byte_t'(si);
         v = mat_apply(m, s);
         for (int j = 0; j < 8; j++) begin
            if (v == (8'h01 << j)) acc = acc | ({56'd0, s} << (8 * j));
         end
      end
      return acc;
   endfunction

   localparam mat8_t ISO_MAP   = build_iso_map();
   localparam mat8_t ISO_UNMAP = build_iso_unmap(ISO_MAP);

   // AES polynomial basis -> composite basis.
   function automatic byte_t iso_map(input byte_t a);
      return mat_apply(ISO_MAP, a);
   endfunction

   // Composite basis -> AES polynomial basis.
   function automatic byte_t iso_unmap(input byte_t a);
      return mat_apply(ISO_UNMAP, a);
   endfunction

endpackage
`default_nettype wire

// File: rtl/gf256_inv.sv
`default_nettype none
// ============================================================================
//  Module   : gf256_inv
//  Purpose  : Combinational GF(2^8) multiplicative inverse (AES field),
//             zero maps to zero. Computed in the composite field
//             GF((2^4)^2). With MAPPED_IN = 1 the input is already in the
//             composite basis (the caller applied iso_map); the output is
//             always in the AES polynomial basis.
//  Revision : 1.0 - initial release
// ============================================================================
module gf256_inv
   import aes_pkg::*;
#(
   parameter bit MAPPED_IN = 1'b0
) (
   input  logic [7:0] a_i,
   output logic [7:0] inv_o
);

   byte_t a_map;
   byte_t a_inv_map;

   generate
      if (MAPPED_IN) begin : g_mapped_in
         assign a_map = a_i;
      end else begin : g_std_in
         assign a_map = iso_map(a_i);
      end
   endgenerate

   assign a_inv_map = gf16sq_inv(a_map);
   assign inv_o     = iso_unmap(a_inv_map);

endmodule
`default_nettype wire

// File: rtl/sbox.sv
`default_nettype none
// ============================================================================
//  Module   : sbox
//  Purpose  : AES forward S-box, y = affine(inv(x)) with registered output
//             and a delay-matched copy of the input byte on my_x.
//             Accepts one byte per clock, no handshake.
//  Config   : SBOX_PIPE_EN - when defined, two register stages (mapped
//             composite-field byte, then y) for 2-cycle latency; otherwise
//             one register stage with 1-cycle latency.
//  Revision : 1.0 - initial release
// ============================================================================
module sbox
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] x,
   output logic [7:0] y,
   output logic [7:0] my_x
);

   byte_t inv_b;
   byte_t y_d;
   byte_t y_q;
   byte_t x_q;

`ifdef SBOX_PIPE_EN
   byte_t map_d;
   byte_t map_q;
   byte_t x1_q;

   // Stage 1 holds x in the composite basis; iso_map(00) = 00, so its reset
   // value pairs with x1_q = 00.
   assign map_d = iso_map(x);

   gf256_inv #(
      .MAPPED_IN (1'b1)
   ) u_inv (
      .a_i   (map_q),
      .inv_o (inv_b)
   );

   assign y_d = affine(inv_b);

   // Two-stage datapath with my_x delayed two cycles alongside it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         map_q <= 8'h00;
         x1_q  <= 8'h00;
         x_q   <= 8'h00;
         y_q   <= SBOX_AFFINE_C;
      end else begin
         map_q <= map_d;
         x1_q  <= x;
         x_q   <= x1_q;
         y_q   <= y_d;
      end
   end
`else
   gf256_inv #(
      .MAPPED_IN (1'b0)
   ) u_inv (
      .a_i   (x),
      .inv_o (inv_b)
   );

   assign y_d = affine(inv_b);

   // Single register stage; reset pair is S(00) = 63.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= 8'h00;
         y_q <= SBOX_AFFINE_C;
      end else begin
         x_q <= x;
         y_q <= y_d;
      end
   end
`endif

   assign y    = y_q;
   assign my_x = x_q;

endmodule
`default_nettype wire

// File: tb/tb_sbox.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sbox
//  Purpose  : Directed self-checking bench for sbox (either configuration,
//             selected by SBOX_PIPE_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sbox;

`ifdef SBOX_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] x     = 8'h00;
   logic [7:0] y;
   logic [7:0] my_x;

   int total = 0;
   int bad   = 0;

   logic [7:0] sb [256];
   logic [7:0] sh [2];

   logic [7:0] vin  [10] = '{8'h00, 8'h01, 8'h10, 8'h53, 8'hFF,
                             8'h02, 8'h80, 8'hC9, 8'hAA, 8'h00};
   logic [7:0] vexp [9]  = '{8'h63, 8'h7C, 8'hCA, 8'hED, 8'h16,
                             8'h77, 8'hCD, 8'hDD, 8'hAC};

   sbox dut (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (x),
      .y     (y),
      .my_x  (my_x)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] aa;
      logic [7:0] bb;
      r  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) r = r ^ aa;
         aa = xtime(aa);
         bb = bb >> 1;
      end
      return r;
   endfunction

   // Reference S-box: inverse as v^254, then the affine formula bit by bit.
   function automatic logic [7:0] ref_sbox(input logic [7:0] v);
      logic [7:0] inv;
      logic [7:0] c;
      logic [7:0] r;
      inv = 8'h01;
      c   = 8'h63;
      r   = 8'h00;
      for (int k = 0; k < 254; k++) inv = gmul(inv, v);
      for (int i = 0; i < 8; i++) begin
         r[i[2:0]] = inv[i[2:0]] ^ inv[3'(i + 4)] ^ inv[3'(i + 5)]
                   ^ inv[3'(i + 6)] ^ inv[3'(i + 7)] ^ c[i[2:0]];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one byte, clock it in, and check the pair against the latency model.
   task automatic step(input logic [7:0] v, input string tag);
      x = v;
      @(posedge clk);
      if (LAT == 2) sh[1] = sh[0];
      sh[0] = v;
      #1;
      chk({tag, "/my_x"}, my_x, sh[LAT-1]);
      chk({tag, "/y"}, y, sb[sh[LAT-1]]);
      chk({tag, "/noX"}, {7'd0, $isunknown({y, my_x})}, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) sb[i] = ref_sbox(8'(i));
      sh[0] = 8'h00;
      sh[1] = 8'h00;

      // Reset state, with the input moving underneath it
      rst_n = 1'b0;
      x     = 8'h5A;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_my_x", my_x, 8'h00);
      chk("rst_y", y, 8'h63);
      x = 8'hC3;
      @(posedge clk);
      #1;
      chk("rst_hold_my_x", my_x, 8'h00);
      chk("rst_hold_y", y, 8'h63);
      @(negedge clk);
      rst_n = 1'b1;

      // Known vectors with hand-computed results
      for (int k = 0; k < 10; k++) begin
         step(vin[k], "vec");
         if (k >= LAT - 1 && (k - (LAT - 1)) < 9) begin
            chk("vec_hand_y", y, vexp[k - (LAT - 1)]);
            chk("vec_hand_my_x", my_x, vin[k - (LAT - 1)]);
         end
      end

      // Hold at FF then wrap to 00
      repeat (3) step(8'hFF, "wrap_hold");
      chk("wrap_ff_y", y, 8'h16);
      chk("wrap_ff_my_x", my_x, 8'hFF);
      step(8'h00, "wrap_to0");
      for (int k = 1; k < LAT; k++) begin
         chk("wrap_prev_y", y, 8'h16);
         step(8'h00, "wrap_to0");
      end
      chk("wrap_00_y", y, 8'h63);
      chk("wrap_00_my_x", my_x, 8'h00);

      // Sweep 00..7F, reset mid-cycle, resume 80..FF
      for (int i = 0; i < 128; i++) step(8'(i), "sweep_lo");
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_async_my_x", my_x, 8'h00);
      chk("midrst_async_y", y, 8'h63);
      @(posedge clk);
      #1;
      chk("midrst_hold_my_x", my_x, 8'h00);
      chk("midrst_hold_y", y, 8'h63);
      @(negedge clk);
      rst_n = 1'b1;
      sh[0] = 8'h00;
      sh[1] = 8'h00;
      for (int i = 128; i < 256; i++) step(8'(i), "sweep_hi");
      n = 0;
      while (my_x !== 8'hFF && n < 8) begin
         step(8'hFF, "sweep_tail");
         n++;
      end
      chk("sweep_end_my_x", my_x, 8'hFF);
      chk("sweep_end_y", y, 8'h16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
